// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline issue controller: instruction field
// positions, the NOP encoding and the status encoding.
package pipeline_pkg;

  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 26;
  localparam int unsigned WSEL_MSB  = 25;
  localparam int unsigned WSEL_LSB  = 21;
  localparam int unsigned RSEL1_MSB = 20;
  localparam int unsigned RSEL1_LSB = 16;
  localparam int unsigned RSEL2_MSB = 15;
  localparam int unsigned RSEL2_LSB = 11;
  // opcode[3]: immediate form, which does not read select 2
  localparam int unsigned IMM_BIT   = 29;

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    STALL = 2'd2,
    DRAIN = 2'd3
  } status_e;

  // Any non-zero opcode writes its destination register.
  function automatic logic writesReg(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB] != '0;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// DEPTH-entry synchronous instruction FIFO with push, pop and flush.
// The head entry is presented combinationally on rdata (NOP when empty).
module issue_fifo
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;

  // DEPTH is a power of two, so the count MSB alone marks full
  assign full  = count[AW];
  assign empty = (count == '0);
  assign rdata = empty ? NOP : mem[rdPtr];

  // Storage write; flush discards anything offered in the same cycle
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wrPtr] <= wdata;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally modulo DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_issue_ctrl.sv
// Issue controller for the three-stage, non-forwarding pipeline. Buffers
// upstream instructions, tracks in-flight writes in a 3-slot scoreboard and
// issues NOP bubbles while the head would read a register not yet written.
module pipeline_issue_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            in_instr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [31:0]            instr_out,
  output logic                   issue,
  output logic [1:0]             status,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       issue_cnt
);

  logic [31:0] headInstr;
  logic        fifoFull;
  logic        fifoEmpty;
  logic        headValid;
  logic        headHazard;
  logic        doPush;
  logic        anyPending;
  status_e     statusNext;

  // Scoreboard slot 0 mirrors S1, slot 1 S2, slot 2 S3
  logic [2:0]  sbWe;
  logic [4:0]  sbWsel [3];

  logic [4:0]  headRs1;
  logic [4:0]  headRs2;
  logic        headImm;

  assign headValid = !fifoEmpty;
  assign headRs1   = headInstr[RSEL1_MSB:RSEL1_LSB];
  assign headRs2   = headInstr[RSEL2_MSB:RSEL2_LSB];
  assign headImm   = headInstr[IMM_BIT];

  assign in_ready  = !fifoFull && !flush;
  assign doPush    = in_valid && in_ready;
  assign issue     = headValid && !headHazard && !flush;
  assign instr_out = issue ? headInstr : NOP;
  assign status    = statusNext;

  issue_fifo #(
    .DEPTH (DEPTH)
  ) u_issue_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (doPush),
    .pop   (issue),
    .flush (flush),
    .wdata (in_instr),
    .rdata (headInstr),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifo_count)
  );

  // RAW check against S1/S2 only; S3 commits before the head reads
  always_comb begin
    headHazard = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (sbWe[i] && ((sbWsel[i] == headRs1) || (!headImm && (sbWsel[i] == headRs2)))) begin
        headHazard = headValid;
      end
    end
  end

  // Status: issuing beats stalling; otherwise pending writes mean drain
  always_comb begin
    anyPending = |sbWe;
    if (issue) begin
      statusNext = ISSUE;
    end else if (headHazard) begin
      statusNext = STALL;
    end else if (anyPending) begin
      statusNext = DRAIN;
    end else begin
      statusNext = IDLE;
    end
  end

  // Scoreboard shifts every cycle; bubbles and flushes load an empty slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbWe      <= '0;
      sbWsel[0] <= '0;
      sbWsel[1] <= '0;
      sbWsel[2] <= '0;
    end else begin
      sbWe      <= {sbWe[1:0], issue && writesReg(headInstr)};
      sbWsel[2] <= sbWsel[1];
      sbWsel[1] <= sbWsel[0];
      sbWsel[0] <= issue ? headInstr[WSEL_MSB:WSEL_LSB] : 5'd0;
    end
  end

  // Saturating statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (headHazard && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (issue && (issue_cnt != '1))      issue_cnt <= issue_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_issue_ctrl.sv
// Self-checking bench for pipeline_issue_ctrl: directed scenarios followed by
// randomized traffic, all checked against a cycle-count based reference model.
module tb_pipeline_issue_ctrl;
  import pipeline_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [31:0]            in_instr = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic                   flush = 1'b0;
  logic [31:0]            instr_out;
  logic                   issue;
  logic [1:0]             status;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [CNT_W-1:0]       stall_cnt;
  logic [CNT_W-1:0]       issue_cnt;

  always #5 clk = ~clk;

  pipeline_issue_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_instr   (in_instr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .instr_out  (instr_out),
    .issue      (issue),
    .status     (status),
    .fifo_count (fifo_count),
    .stall_cnt  (stall_cnt),
    .issue_cnt  (issue_cnt)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: queued instructions plus a log of issued writes stamped
  // with the cycle they issued; hazard/drain follow from cycle distance.
  typedef struct {
    int         cyc;
    logic [4:0] wsel;
  } wr_t;

  logic [31:0] mq[$];
  wr_t         wrLog[$];
  int          cycleNo = 0;
  int          mStall  = 0;
  int          mIssue  = 0;

  logic        obsIssue;
  logic        obsReady;
  logic [1:0]  obsStatus;
  logic [31:0] obsCount;
  logic [31:0] obsStall;
  logic [31:0] obsIssueCnt;
  logic        accepted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [4:0] wd,
                                     input logic [4:0] r1, input logic [4:0] r2);
    return {opc, wd, r1, r2, 11'd0};
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // A write issued d cycles ago blocks readers for d = 1 or 2
  function automatic logic mHazard(input logic [31:0] h);
    foreach (wrLog[i]) begin
      int d;
      d = cycleNo - wrLog[i].cyc;
      if (d >= 1 && d <= 2) begin
        if (wrLog[i].wsel == h[20:16]) return 1'b1;
        if (!h[29] && wrLog[i].wsel == h[15:11]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // A write is still in the pipeline for three cycles after it issued
  function automatic logic mPending();
    foreach (wrLog[i]) begin
      if (cycleNo - wrLog[i].cyc <= 3) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic step(input logic v, input logic [31:0] ins, input logic fl);
    logic        hv, hz, iss, rdy;
    logic [31:0] head;
    logic [1:0]  st;
    @(negedge clk);
    in_valid = v;
    in_instr = ins;
    flush    = fl;
    #1;
    hv   = (mq.size() > 0);
    head = hv ? mq[0] : 32'h0;
    hz   = hv && mHazard(head);
    iss  = hv && !hz && !fl;
    rdy  = (mq.size() < DEPTH) && !fl;
    if (iss)             st = 2'd1;
    else if (hz)         st = 2'd2;
    else if (mPending()) st = 2'd3;
    else                 st = 2'd0;
    check("instr_out",  instr_out,  iss ? head : 32'h0);
    check("issue",      32'(issue), 32'(iss));
    check("status",     32'(status), 32'(st));
    check("in_ready",   32'(in_ready), 32'(rdy));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("stall_cnt",  32'(stall_cnt), 32'(sat(mStall)));
    check("issue_cnt",  32'(issue_cnt), 32'(sat(mIssue)));
    obsIssue    = issue;
    obsReady    = in_ready;
    obsStatus   = status;
    obsCount    = 32'(fifo_count);
    obsStall    = 32'(stall_cnt);
    obsIssueCnt = 32'(issue_cnt);
    accepted    = v && rdy;
    @(posedge clk);
    if (iss) begin
      void'(mq.pop_front());
      mIssue++;
      if (head[31:26] != 6'd0) wrLog.push_back(wr_t'{cycleNo, head[25:21]});
    end
    if (hz) mStall++;
    if (fl) mq.delete();
    if (v && rdy) mq.push_back(ins);
    cycleNo++;
    while (wrLog.size() > 0 && (cycleNo - wrLog[0].cyc) > 3) void'(wrLog.pop_front());
  endtask

  // Reset is raised between clock edges so its effect must be immediate
  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    check("rst_instr_out",  instr_out, 32'h0);
    check("rst_issue",      32'(issue), 32'd0);
    check("rst_status",     32'(status), 32'd0);
    check("rst_in_ready",   32'(in_ready), 32'd1);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_stall_cnt",  32'(stall_cnt), 32'd0);
    check("rst_issue_cnt",  32'(issue_cnt), 32'd0);
    mq.delete();
    wrLog.delete();
    mStall = 0;
    mIssue = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0]  pat;
    logic [2:0]  pat3;
    logic [31:0] chain [7];
    int          idx;
    int          maxCnt;
    logic        sawBlocked;
    logic [5:0]  opc;

    // Dependent pair: r3 <- r1,r2 then r4 <- r3,r1
    doReset();
    step(1'b1, mk(6'h01, 5'd3, 5'd1, 5'd2), 1'b0);
    step(1'b1, mk(6'h01, 5'd4, 5'd3, 5'd1), 1'b0); pat[3] = obsIssue;
    step(1'b0, '0, 1'b0);                          pat[2] = obsIssue;
    step(1'b0, '0, 1'b0);                          pat[1] = obsIssue;
    step(1'b0, '0, 1'b0);                          pat[0] = obsIssue;
    check("pair_pattern", 32'(pat), 32'b1001);
    step(1'b0, '0, 1'b0);
    check("pair_stall_cnt", obsStall, 32'd2);
    check("pair_issue_cnt", obsIssueCnt, 32'd2);
    check("pair_drain1", 32'(obsStatus), 32'(DRAIN));
    step(1'b0, '0, 1'b0); check("pair_drain2", 32'(obsStatus), 32'(DRAIN));
    step(1'b0, '0, 1'b0); check("pair_drain3", 32'(obsStatus), 32'(DRAIN));
    step(1'b0, '0, 1'b0); check("pair_idle",   32'(obsStatus), 32'(IDLE));

    // Independent stream issues back-to-back
    doReset();
    step(1'b1, mk(6'h01, 5'd1, 5'd2, 5'd3), 1'b0);
    step(1'b1, mk(6'h01, 5'd4, 5'd5, 5'd6), 1'b0); pat3[2] = obsIssue;
    step(1'b1, mk(6'h01, 5'd7, 5'd8, 5'd9), 1'b0); pat3[1] = obsIssue;
    step(1'b0, '0, 1'b0);                          pat3[0] = obsIssue;
    check("indep_pattern", 32'(pat3), 32'b111);
    step(1'b0, '0, 1'b0);
    check("indep_stall_cnt", obsStall, 32'd0);
    check("indep_issue_cnt", obsIssueCnt, 32'd3);

    // Immediate-form consumer ignores bits [15:11]
    doReset();
    step(1'b1, mk(6'h01, 5'd3, 5'd1, 5'd2), 1'b0);
    step(1'b1, mk(6'h08, 5'd6, 5'd5, 5'd3), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    check("imm_stall_cnt", obsStall, 32'd0);

    // Same consumer in register form stalls twice
    doReset();
    step(1'b1, mk(6'h01, 5'd3, 5'd1, 5'd2), 1'b0);
    step(1'b1, mk(6'h01, 5'd6, 5'd5, 5'd3), 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0);
    check("reg_stall_cnt", obsStall, 32'd2);

    // Dependent chain fills the FIFO while the head keeps stalling
    doReset();
    for (int k = 0; k < 7; k++) chain[k] = mk(6'h01, 5'(k + 1), 5'(k), 5'(k));
    idx        = 0;
    maxCnt     = 0;
    sawBlocked = 1'b0;
    for (int i = 0; i < 28; i++) begin
      step(idx < 7, chain[(idx < 7) ? idx : 6], 1'b0);
      if (int'(obsCount) > maxCnt) maxCnt = int'(obsCount);
      if (idx < 7 && !obsReady) sawBlocked = 1'b1;
      if (accepted) idx++;
    end
    check("full_max_count", 32'(maxCnt), 32'd4);
    check("full_blocked",   32'(sawBlocked), 32'd1);
    check("full_all_taken", 32'(idx), 32'd7);

    // Flush with three queued entries and the producer in S2
    doReset();
    step(1'b1, mk(6'h01, 5'd9,  5'd0, 5'd0), 1'b0);
    step(1'b1, mk(6'h01, 5'd3,  5'd9, 5'd9), 1'b0);
    step(1'b1, mk(6'h01, 5'd10, 5'd3, 5'd3), 1'b0);
    step(1'b1, mk(6'h01, 5'd11, 5'd3, 5'd3), 1'b0);
    step(1'b1, mk(6'h01, 5'd12, 5'd3, 5'd3), 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, mk(6'h01, 5'd13, 5'd1, 5'd1), 1'b1);
    check("flush_count_before", obsCount, 32'd3);
    check("flush_in_ready",     32'(obsReady), 32'd0);
    check("flush_no_issue",     32'(obsIssue), 32'd0);
    step(1'b0, '0, 1'b0);
    check("flush_count_after", obsCount, 32'd0);
    check("flush_drain",       32'(obsStatus), 32'(DRAIN));
    step(1'b0, '0, 1'b0);
    check("flush_idle",        32'(obsStatus), 32'(IDLE));

    // Randomized traffic with a mid-stream reset; small register range
    // forces frequent hazards and the 4-bit counters saturate
    doReset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      case ($urandom % 4)
        0:       opc = 6'h00;
        1:       opc = 6'h01;
        2:       opc = 6'h08;
        default: opc = 6'($urandom % 64);
      endcase
      step(($urandom % 4) != 0,
           mk(opc, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)),
              5'($urandom_range(0, 5))),
           ($urandom % 20) == 0);
    end
    step(1'b0, '0, 1'b0);
    check("rand_issue_saturated", obsIssueCnt, 32'(CMAX));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
